sm4_key_expansion: RTL and testbench
====================================

// Module: sm4_key_expansion
// PURPOSE
//  Iterative SM4 key schedule. Takes a 128-bit master key and produces the 32 round
//  keys rk0..rk31, one per clock. Each round feeds K1^K2^K3^CK_i into the existing
//  T' key transform. The round keys stream into the SM4 round datapath of the
//  encryption accelerator.
// PARAMETERS
//  ROUNDS     32   number of rounds and round keys (fixed by SM4; not for reuse)
//  IDX_W      5    width of rk_idx / rk_rd_addr
// PORTS
//  clk        in   1    clock
//  rst_n      in   1    synchronous, active-low reset
//  start      in   1    one-cycle request; sampled only in IDLE
//  mk         in   128  master key {MK0,MK1,MK2,MK3}, MK0 = mk[127:96]; sampled with start
//  busy       out  1    high while rounds are being computed
//  rk_valid   out  1    rk_out/rk_idx valid this cycle
//  rk_out     out  32   round key rk_i
//  rk_idx     out  5    i of rk_out
//  done       out  1    one-cycle pulse, coincident with rk_idx==31
//  keys_ready out  1    [SM4_RK_STORE_EN] all 32 keys stored
//  rk_rd_addr in   5    [SM4_RK_STORE_EN] read address
//  rk_rd_data out  32   [SM4_RK_STORE_EN] combinational read of stored rk[rk_rd_addr]
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active-low (rst_n sampled at posedge clk).
//  - Reset: state=IDLE; busy, rk_valid, done, keys_ready = 0; rk_out = 0; rk_idx = 0;
//    K regs = 0; round = 0; store entries = 0.
//  - FSM IDLE -> RUN -> IDLE.
//    - IDLE: start=1 at edge E0 loads K0..K3 = MK_j ^ FK_j and sets round=0, state=RUN.
//      FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
//    - RUN: each edge computes rk = K0 ^ T'(K1^K2^K3^CK_round).
//      - Shifts {K0..K3} <= {K1,K2,K3,rk}.
//      - Registers rk_out=rk, rk_idx=round, rk_valid=1, then round++.
//    - At edge E32 (round==31): state=IDLE and done=1 with rk_idx=31.
//  - Latency: rk_i is valid in the cycle after edge E(i+1), so rk31 is 32 cycles after start.
//  - busy = (state==RUN). It is low in the done cycle, and a new start is accepted in that cycle.
//  - rk_valid is a single-cycle qualifier per key. It has no backpressure, so the consumer
//    must accept every key.
//  - CK_i is generated on the fly with no ROM: byte j of CK_i = ((4i+j)*7) mod 256,
//    with j=0 as the MSB. The multiply uses 8-bit wrap arithmetic.
//  - All XORs are 32-bit. T' is purely combinational, giving a single-cycle round.
//  - start while busy is ignored, and mk is not re-sampled.
//  - start and rst_n=0 in the same cycle: reset wins.
//  - rst_n=0 mid-run aborts the run: no done pulse, all outputs return to reset values.
//  - mk changing during RUN has no effect.
// CONFIGURATION
//  SM4_RK_STORE_EN defined:
//    - Adds a 32x32 store, written at the same edge as rk_out (addr = round).
//    - keys_ready is set at E32 and cleared when a new start is accepted.
//    - Reads during a re-run return a mix of old and new keys; consumers gate on keys_ready.
//    - Intended for decryption, which uses reverse order rk31..rk0.
//  Undefined:
//    - The store and the keys_ready, rk_rd_addr, rk_rd_data ports are absent.
//    - The streaming interface is unchanged.
// STRUCTURE
//  - Shared package sm4_pkg: FK0..FK3 constants, SM4_ROUNDS=32, state enum {IDLE,RUN}.
//  - One sub-module: the existing Transform_for_key_exp (T', sbox_replace x4 + L'),
//    instantiated once.
//  - CK generation and the K shift register stay in this module.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles -> busy=0, rk_valid=0, done=0, rk_out=0.
//  2. GB/T 32907 key: mk=0123456789ABCDEFFEDCBA9876543210, start pulse.
//     -> rk0=F12186F9, rk1=41662B61, rk31=9124A012.
//     -> done exactly 32 cycles after start; rk_idx runs 0..31 contiguously.
//  3. Check internal CK on the fly: round 0 -> 00070E15, round 1 -> 1C232A31,
//     round 31 -> 646B7279.
//  4. Pulse start again at rounds 5 and 20 with a different mk.
//     -> ignored; keys match test 2.
//     Then issue start in the done cycle -> accepted; new rk0 one cycle after busy rises.
//  5. Drop rst_n at round 10 -> next cycle busy=0 and rk_valid=0, no done pulse.
//     A fresh start then yields test-2 keys.
//  6. [SM4_RK_STORE_EN] After test 2: keys_ready=1; rd_addr=0 -> F12186F9,
//     rd_addr=31 -> 9124A012. A new start clears keys_ready the next cycle.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 constants: system parameter FK, the S-box, the round count and the
// key-schedule FSM states.
package sm4_pkg;

  localparam int SM4_ROUNDS = 32;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [7:0] SM4_SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

endpackage

// File: rtl/sm4_key_expansion_transform.sv
// T' key transform: four parallel S-box substitutions followed by the key-schedule
// linear layer L'(B) = B ^ (B <<< 13) ^ (B <<< 23). Purely combinational.
module Transform_for_key_exp
  import sm4_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  function automatic logic [7:0] sbox_replace(input logic [7:0] b);
    return SM4_SBOX[b];
  endfunction

  logic [31:0] tau;

  always_comb begin
    tau = '0;
    for (int j = 0; j < 4; j++) begin
      tau[8*j +: 8] = sbox_replace(din[8*j +: 8]);
    end
  end

  assign dout = tau ^ {tau[18:0], tau[31:19]} ^ {tau[8:0], tau[31:9]};

endmodule

// File: rtl/sm4_key_expansion.sv
// Iterative SM4 key schedule: one round key per clock, rk0..rk31 streamed out.
// Optional round-key store for reverse-order (decryption) reads: SM4_RK_STORE_EN.
module sm4_key_expansion
  import sm4_pkg::*;
#(
  parameter int ROUNDS = SM4_ROUNDS,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [127:0]      mk,
  output logic              busy,
  output logic              rk_valid,
  output logic [31:0]       rk_out,
  output logic [IDX_W-1:0]  rk_idx,
  output logic              done
`ifdef SM4_RK_STORE_EN
  ,
  output logic              keys_ready,
  input  logic [IDX_W-1:0]  rk_rd_addr,
  output logic [31:0]       rk_rd_data
`endif
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] round_q, round_d;
  logic [31:0]      k_q [4];
  logic [31:0]      k_d [4];
  logic [31:0]      rk_out_q, rk_out_d;
  logic [IDX_W-1:0] rk_idx_q, rk_idx_d;
  logic             rk_valid_q, rk_valid_d;
  logic             done_q, done_d;

  logic [31:0]      ck;
  logic [31:0]      t_in;
  logic [31:0]      t_out;
  logic [31:0]      rk;

  // CK byte j of round i is (4i+j)*7 mod 256, computed instead of stored.
  always_comb begin
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      ck[31-8*j -: 8] = (8'({round_q, 2'b00}) + 8'(j)) * 8'd7;
    end
  end

  assign t_in = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck;

  Transform_for_key_exp u_t_prime (
    .din  (t_in),
    .dout (t_out)
  );

  assign rk = k_q[0] ^ t_out;

`ifdef SM4_RK_STORE_EN
  logic        keys_ready_q, keys_ready_d;
  logic        store_we;
  logic [31:0] store_q [ROUNDS];
`endif

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    k_d        = k_q;
    rk_out_d   = rk_out_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = 1'b0;
    done_d     = 1'b0;
`ifdef SM4_RK_STORE_EN
    keys_ready_d = keys_ready_q;
    store_we     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d[0]  = mk[127:96] ^ FK0;
          k_d[1]  = mk[95:64]  ^ FK1;
          k_d[2]  = mk[63:32]  ^ FK2;
          k_d[3]  = mk[31:0]   ^ FK3;
          round_d = '0;
          state_d = RUN;
`ifdef SM4_RK_STORE_EN
          keys_ready_d = 1'b0;
`endif
        end
      end
      RUN: begin
        k_d[0]     = k_q[1];
        k_d[1]     = k_q[2];
        k_d[2]     = k_q[3];
        k_d[3]     = rk;
        rk_out_d   = rk;
        rk_idx_d   = round_q;
        rk_valid_d = 1'b1;
        round_d    = round_q + IDX_W'(1);
`ifdef SM4_RK_STORE_EN
        store_we   = 1'b1;
`endif
        if (round_q == IDX_W'(ROUNDS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
`ifdef SM4_RK_STORE_EN
          keys_ready_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      round_q    <= '0;
      for (int i = 0; i < 4; i++) k_q[i] <= '0;
      rk_out_q   <= '0;
      rk_idx_q   <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      k_q        <= k_d;
      rk_out_q   <= rk_out_d;
      rk_idx_q   <= rk_idx_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign rk_valid = rk_valid_q;
  assign rk_out   = rk_out_q;
  assign rk_idx   = rk_idx_q;
  assign done     = done_q;

`ifdef SM4_RK_STORE_EN
  // Store is written on the same edge that registers rk_out; readers gate on keys_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      keys_ready_q <= 1'b0;
      for (int a = 0; a < ROUNDS; a++) store_q[a] <= '0;
    end else begin
      keys_ready_q <= keys_ready_d;
      if (store_we) store_q[round_q] <= rk;
    end
  end

  assign keys_ready = keys_ready_q;
  assign rk_rd_data = store_q[rk_rd_addr];
`endif

endmodule

// File: tb/tb_sm4_key_expansion.sv
// Directed self-checking bench for the SM4 key schedule using the GB/T 32907 example key.
module tb_sm4_key_expansion;

  localparam logic [127:0] KEY  = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KEY2 = 128'hDEADBEEFCAFEF00D0011223344556677;
  localparam logic [31:0]  RK0  = 32'hF12186F9;
  localparam logic [31:0]  RK1  = 32'h41662B61;
  localparam logic [31:0]  RK31 = 32'h9124A012;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] mk;
  logic         busy;
  logic         rk_valid;
  logic [31:0]  rk_out;
  logic [4:0]   rk_idx;
  logic         done;
`ifdef SM4_RK_STORE_EN
  logic         keys_ready;
  logic [4:0]   rk_rd_addr;
  logic [31:0]  rk_rd_data;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] cap_rk  [32];
  logic [4:0]  cap_idx [32];
  logic [31:0] cap_ck  [32];
  logic        cap_vld [32];
  int          cap_valid_cnt;
  int          cap_done_cnt;
  int          cap_done_at;
  logic        cap_busy0;

  sm4_key_expansion dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mk         (mk),
    .busy       (busy),
    .rk_valid   (rk_valid),
    .rk_out     (rk_out),
    .rk_idx     (rk_idx),
    .done       (done)
`ifdef SM4_RK_STORE_EN
    ,
    .keys_ready (keys_ready),
    .rk_rd_addr (rk_rd_addr),
    .rk_rd_data (rk_rd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run with key, optionally pulse start again at rounds inj_a/inj_b with mk=alt,
  // and capture the 32 output cycles.
  task automatic collect(input logic [127:0] key, input int inj_a, input int inj_b,
                         input logic [127:0] alt);
    mk = key;
    start = 1'b1;
    tick();
    start = 1'b0;
    mk = alt;
    cap_busy0 = busy;
    cap_valid_cnt = 0;
    cap_done_cnt = 0;
    cap_done_at = -1;
    for (int i = 0; i < 32; i++) begin
      cap_ck[i] = dut.ck;
      if (i == inj_a || i == inj_b) start = 1'b1;
      tick();
      start = 1'b0;
      cap_rk[i]  = rk_out;
      cap_idx[i] = rk_idx;
      cap_vld[i] = rk_valid;
      if (rk_valid) cap_valid_cnt++;
      if (done) begin
        cap_done_cnt++;
        cap_done_at = i + 1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid: got %0b want 0", rk_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (rk_out !== 32'h0) begin errors++; $display("FAIL reset_rk_out: got %h want 00000000", rk_out); end
    checks++; if (rk_idx !== 5'd0) begin errors++; $display("FAIL reset_rk_idx: got %0d want 0", rk_idx); end
`ifdef SM4_RK_STORE_EN
    checks++; if (keys_ready !== 1'b0) begin errors++; $display("FAIL reset_keys_ready: got %0b want 0", keys_ready); end
`endif
    // start together with reset: reset wins
    start = 1'b1;
    mk = KEY;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_vs_start: busy got %0b want 0", busy); end
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL reset_vs_start_after: busy %0b rk_valid %0b want 0 0", busy, rk_valid);
    end
  endtask

  task automatic test_gbt_key();
    int bad_idx;
    collect(KEY, -1, -1, KEY2);
    checks++; if (cap_busy0 !== 1'b1) begin errors++; $display("FAIL gbt_busy_after_start: got %0b want 1", cap_busy0); end
    checks++; if (cap_rk[0] !== RK0) begin errors++; $display("FAIL gbt_rk0: got %h want %h", cap_rk[0], RK0); end
    checks++; if (cap_rk[1] !== RK1) begin errors++; $display("FAIL gbt_rk1: got %h want %h", cap_rk[1], RK1); end
    checks++; if (cap_rk[31] !== RK31) begin errors++; $display("FAIL gbt_rk31: got %h want %h", cap_rk[31], RK31); end
    bad_idx = 0;
    for (int i = 0; i < 32; i++) if (cap_idx[i] !== 5'(i) || cap_vld[i] !== 1'b1) bad_idx++;
    checks++; if (bad_idx != 0) begin errors++; $display("FAIL gbt_idx_sequence: %0d bad cycles want 0", bad_idx); end
    checks++; if (cap_valid_cnt != 32) begin errors++; $display("FAIL gbt_valid_count: got %0d want 32", cap_valid_cnt); end
    checks++; if (cap_done_cnt != 1) begin errors++; $display("FAIL gbt_done_count: got %0d want 1", cap_done_cnt); end
    checks++; if (cap_done_at != 32) begin errors++; $display("FAIL gbt_done_latency: got %0d want 32", cap_done_at); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gbt_busy_in_done: got %0b want 0", busy); end
`ifdef SM4_RK_STORE_EN
    checks++; if (keys_ready !== 1'b1) begin errors++; $display("FAIL store_keys_ready: got %0b want 1", keys_ready); end
    rk_rd_addr = 5'd0;
    #1;
    checks++; if (rk_rd_data !== RK0) begin errors++; $display("FAIL store_rd0: got %h want %h", rk_rd_data, RK0); end
    rk_rd_addr = 5'd31;
    #1;
    checks++; if (rk_rd_data !== RK31) begin errors++; $display("FAIL store_rd31: got %h want %h", rk_rd_data, RK31); end
`endif
    tick();
    checks++; if (done !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL gbt_after_done: done %0b rk_valid %0b want 0 0", done, rk_valid);
    end
  endtask

  task automatic test_ck();
    checks++; if (cap_ck[0] !== 32'h00070E15) begin errors++; $display("FAIL ck_round0: got %h want 00070E15", cap_ck[0]); end
    checks++; if (cap_ck[1] !== 32'h1C232A31) begin errors++; $display("FAIL ck_round1: got %h want 1C232A31", cap_ck[1]); end
    checks++; if (cap_ck[31] !== 32'h646B7279) begin errors++; $display("FAIL ck_round31: got %h want 646B7279", cap_ck[31]); end
  endtask

  task automatic test_back_to_back();
    collect(KEY, 5, 20, KEY2);
    checks++; if (cap_rk[0] !== RK0 || cap_rk[1] !== RK1 || cap_rk[31] !== RK31) begin
      errors++; $display("FAIL ignore_start_keys: got %h %h %h want %h %h %h", cap_rk[0], cap_rk[1], cap_rk[31], RK0, RK1, RK31);
    end
    checks++; if (cap_done_at != 32 || cap_done_cnt != 1) begin
      errors++; $display("FAIL ignore_start_done: at %0d count %0d want 32 1", cap_done_at, cap_done_cnt);
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL done_cycle_state: done %0b busy %0b want 1 0", done, busy);
    end
    // new start in the done cycle
    collect(KEY, -1, -1, KEY2);
    checks++; if (cap_busy0 !== 1'b1) begin errors++; $display("FAIL done_cycle_start_busy: got %0b want 1", cap_busy0); end
    checks++; if (cap_vld[0] !== 1'b1 || cap_idx[0] !== 5'd0 || cap_rk[0] !== RK0) begin
      errors++; $display("FAIL done_cycle_start_rk0: vld %0b idx %0d rk %h want 1 0 %h", cap_vld[0], cap_idx[0], cap_rk[0], RK0);
    end
    checks++; if (cap_rk[31] !== RK31) begin errors++; $display("FAIL done_cycle_start_rk31: got %h want %h", cap_rk[31], RK31); end
    tick();
  endtask

  task automatic test_abort();
    int stray;
    mk = KEY;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: busy %0b rk_valid %0b want 0 0", busy, rk_valid);
    end
    checks++; if (rk_out !== 32'h0 || rk_idx !== 5'd0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_values: rk_out %h rk_idx %0d done %0b want 0 0 0", rk_out, rk_idx, done);
    end
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || rk_valid || busy) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL abort_no_done: %0d active cycles want 0", stray); end
    collect(KEY, -1, -1, KEY2);
    checks++; if (cap_rk[0] !== RK0 || cap_rk[31] !== RK31 || cap_done_at != 32) begin
      errors++; $display("FAIL abort_rerun: rk0 %h rk31 %h done_at %0d want %h %h 32", cap_rk[0], cap_rk[31], cap_done_at, RK0, RK31);
    end
  endtask

`ifdef SM4_RK_STORE_EN
  task automatic test_store_clear();
    int seen;
    mk = KEY;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (keys_ready !== 1'b0) begin errors++; $display("FAIL store_clear_on_start: got %0b want 0", keys_ready); end
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      tick();
      if (done) seen = 1;
    end
    checks++; if (seen != 1 || keys_ready !== 1'b1) begin
      errors++; $display("FAIL store_ready_again: done_seen %0d keys_ready %0b want 1 1", seen, keys_ready);
    end
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mk = '0;
`ifdef SM4_RK_STORE_EN
    rk_rd_addr = '0;
`endif
    test_reset();
    test_gbt_key();
    test_ck();
    test_back_to_back();
    test_abort();
`ifdef SM4_RK_STORE_EN
    test_store_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
